// File: rtl/frame_streamer_pkg.sv
// Shared constants for the AHB frame streamer: register map, bit positions,
// AHB encodings and the pixel-pack helper.
package frame_streamer_pkg;

  localparam int W_BURST = 3;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_SIZE   = 3'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_CLR      = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int CTRL_IRQ_EN   = 3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_DONE  = 2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Keeps only the packed {R,G,B} field; a 32-bit shift yields 0, so 3*pix_w==32 keeps all bits.
  function automatic logic [31:0] pack_pixel(input logic [31:0] wdata, input int unsigned pix_w);
    logic [31:0] mask;
    mask = (32'h1 << (3 * pix_w)) - 32'h1;
    return wdata & mask;
  endfunction

endpackage

// File: rtl/ahb_frame_streamer_fifo.sv
// Synchronous beat FIFO with a first-word registered head; level counts the
// head register plus the storage array so capacity is exactly DEPTH beats.
module frame_stream_fifo
  import frame_streamer_pkg::*;
#(
  parameter int DW    = 48,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [LW-1:0] o_level
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_mem_cnt;
  logic          r_head_valid;
  logic [DW-1:0] r_head;

  logic w_pop;
  logic w_push;
  logic w_load;

  assign o_level = r_mem_cnt + LW'(r_head_valid);
  assign o_full  = (o_level == LW'(DEPTH));
  assign o_empty = !r_head_valid;
  assign o_data  = r_head;

  assign w_pop  = i_pop & r_head_valid;
  assign w_push = i_push & (!o_full | w_pop);
  // The head refills from storage whenever it is empty or being consumed.
  assign w_load = (r_mem_cnt != '0) & (!r_head_valid | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_cnt    <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '0;
    end else if (i_clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_cnt    <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_head   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_load})
        2'b10:   r_mem_cnt <= r_mem_cnt + LW'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - LW'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      if (w_load)     r_head_valid <= 1'b1;
      else if (w_pop) r_head_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_frame_streamer.sv
// AHB-Lite pixel slave streaming lane-grouped beats with frame markers.
// Optional FRAME_STREAMER_IRQ_EN adds the irq port and CTRL bit3 irq_en.
module ahb_frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int IMG_PIX_W = 8,
  parameter int N_LANE    = 2,
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          sl_HSEL,
  input  logic                          sl_HREADY,
  input  logic                          sl_HWRITE,
  input  logic [1:0]                    sl_HTRANS,
  input  logic [W_BURST-1:0]            sl_HBURST,
  input  logic [2:0]                    sl_HSIZE,
  input  logic [31:0]                   sl_HADDR,
  input  logic [31:0]                   sl_HWDATA,
  output logic                          out_sl_HREADY,
  output logic [1:0]                    out_sl_HRESP,
  output logic [31:0]                   out_sl_HRDATA,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_LANE*3*IMG_PIX_W-1:0] out_pix,
  output logic                          out_sof,
  output logic                          out_eol
`ifdef FRAME_STREAMER_IRQ_EN
  ,
  output logic                          irq
`endif
);

  localparam int PW = 3 * IMG_PIX_W;
  localparam int BW = N_LANE * PW;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int FW = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  logic          r_dp_valid;
  logic          r_dp_write;
  logic [2:0]    r_dp_reg;
  logic          r_enable;
  logic          r_frame_done;
  logic [15:0]   r_width;
  logic [15:0]   r_height;
  logic [15:0]   r_col;
  logic [15:0]   r_row;
  logic [FW-1:0] r_fill;
  logic          r_hold;

  logic          w_dp_wr;
  logic          w_wr_ctrl;
  logic          w_wr_data;
  logic          w_wr_size;
  logic          w_clr;
  logic          w_last_slot;
  logic          w_stall;
  logic          w_data_done;
  logic          w_push;
  logic          w_fire;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [LW-1:0] w_level;
  logic [BW-1:0] w_group;
  logic [31:0]   w_pix32;
  logic [PW-1:0] w_pix;
  logic [15:0]   w_col_next;
  logic          w_eol;
  logic          w_last_row;
  logic          w_at_origin;
  logic          w_frame_end;
  logic          w_unused;

  assign w_dp_wr   = r_dp_valid & r_dp_write;
  assign w_wr_ctrl = w_dp_wr & (r_dp_reg == REG_CTRL);
  assign w_wr_data = w_dp_wr & (r_dp_reg == REG_DATA);
  assign w_wr_size = w_dp_wr & (r_dp_reg == REG_SIZE);
  assign w_clr     = w_wr_ctrl & sl_HWDATA[CTRL_CLR];

  assign w_pix32 = pack_pixel(sl_HWDATA, IMG_PIX_W);
  assign w_pix   = w_pix32[PW-1:0];

  // A beat leaving this cycle frees the slot the completing write needs.
  assign w_last_slot = (r_fill == FW'(N_LANE - 1));
  assign w_fire      = out_valid & out_ready;
  assign w_stall     = w_wr_data & w_last_slot & w_fifo_full & !w_fire;
  assign w_data_done = w_wr_data & !w_stall;
  assign w_push      = w_data_done & w_last_slot;

  assign out_sl_HREADY = !w_stall;
  assign out_sl_HRESP  = HRESP_OKAY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_reg   <= 3'd0;
    end else if (sl_HREADY) begin
      r_dp_valid <= sl_HSEL & sl_HTRANS[1];
      r_dp_write <= sl_HWRITE;
      r_dp_reg   <= sl_HADDR[4:2];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LANE; gi++) begin : g_lane
      if (gi < N_LANE - 1) begin : g_slot
        logic [PW-1:0] r_slot;
        always_ff @(posedge HCLK or negedge HRESETn) begin
          if (!HRESETn)                              r_slot <= '0;
          else if (w_data_done && r_fill == FW'(gi)) r_slot <= w_pix;
        end
        assign w_group[gi*PW +: PW] = r_slot;
      end else begin : g_tail
        assign w_group[gi*PW +: PW] = w_pix;
      end
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)         r_fill <= '0;
    else if (w_clr)       r_fill <= '0;
    else if (w_data_done) r_fill <= w_last_slot ? '0 : r_fill + FW'(1);
  end

  frame_stream_fifo #(
    .DW    (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_data  (w_group),
    .i_pop   (w_fire),
    .o_data  (out_pix),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_level (w_level)
  );

  // r_hold keeps an offered beat alive after enable is cleared.
  assign out_valid = !w_fifo_empty & (r_enable | r_hold);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)   r_hold <= 1'b0;
    else if (w_clr) r_hold <= 1'b0;
    else            r_hold <= out_valid & !out_ready;
  end

  assign w_col_next  = r_col + 16'(N_LANE);
  assign w_eol       = (w_col_next >= r_width);
  assign w_last_row  = ((r_row + 16'd1) >= r_height);
  assign w_at_origin = (r_col == 16'd0) && (r_row == 16'd0);
  assign w_frame_end = w_fire & w_eol & w_last_row & !w_clr;

  assign out_sof = out_valid & w_at_origin;
  assign out_eol = out_valid & w_eol;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_col <= 16'd0;
      r_row <= 16'd0;
    end else if (w_clr) begin
      r_col <= 16'd0;
      r_row <= 16'd0;
    end else if (w_fire) begin
      if (w_eol) begin
        r_col <= 16'd0;
        r_row <= w_last_row ? 16'd0 : r_row + 16'd1;
      end else begin
        r_col <= w_col_next;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_enable     <= 1'b0;
      r_frame_done <= 1'b0;
      r_width      <= 16'(WIDTH);
      r_height     <= 16'(HEIGHT);
    end else begin
      if (w_wr_ctrl) r_enable <= sl_HWDATA[CTRL_EN];
      if (w_wr_size && w_at_origin) begin
        r_width  <= sl_HWDATA[15:0];
        r_height <= sl_HWDATA[31:16];
      end
      if (w_frame_end)                                  r_frame_done <= 1'b1;
      else if (w_wr_ctrl && sl_HWDATA[CTRL_DONE_CLR]) r_frame_done <= 1'b0;
    end
  end

`ifdef FRAME_STREAMER_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)       r_irq_en <= 1'b0;
    else if (w_wr_ctrl) r_irq_en <= sl_HWDATA[CTRL_IRQ_EN];
  end

  assign irq = r_frame_done & r_irq_en;
`endif

  always_comb begin
    out_sl_HRDATA = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_reg)
        REG_CTRL: begin
          out_sl_HRDATA[CTRL_EN] = r_enable;
`ifdef FRAME_STREAMER_IRQ_EN
          out_sl_HRDATA[CTRL_IRQ_EN] = r_irq_en;
`endif
        end
        REG_STATUS: begin
          out_sl_HRDATA[ST_EMPTY] = (w_level == '0);
          out_sl_HRDATA[ST_FULL]  = w_fifo_full;
          out_sl_HRDATA[ST_DONE]  = r_frame_done;
          out_sl_HRDATA[31:16]    = 16'(w_level);
        end
        REG_SIZE: out_sl_HRDATA = {r_height, r_width};
        default:  out_sl_HRDATA = '0;
      endcase
    end
  end

  assign w_unused = ^{sl_HBURST, sl_HSIZE, sl_HADDR[31:5], sl_HADDR[1:0], w_pix32};

endmodule

// File: tb/tb_ahb_frame_streamer.sv
// Directed bench for ahb_frame_streamer (N_LANE=2, 8-bit colour, DEPTH=16);
// irq checks run when FRAME_STREAMER_IRQ_EN is defined.
module tb_ahb_frame_streamer;
  import frame_streamer_pkg::*;

  localparam logic [31:0] A_CTRL   = 32'h0000_0000;
  localparam logic [31:0] A_STATUS = 32'h0000_0004;
  localparam logic [31:0] A_DATA   = 32'h0000_0008;
  localparam logic [31:0] A_SIZE   = 32'h0000_000C;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL, HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic [31:0] HADDR, HWDATA;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;
  logic        out_valid, out_ready, out_sof, out_eol;
  logic [47:0] out_pix;
`ifdef FRAME_STREAMER_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;
  int nb    = 0;
  logic [47:0] b_pix [64];
  logic        b_sof [64];
  logic        b_eol [64];

  ahb_frame_streamer #(
    .IMG_PIX_W (8), .N_LANE (2), .DEPTH (16), .WIDTH (256), .HEIGHT (256)
  ) dut (
    .HCLK (HCLK), .HRESETn (HRESETn),
    .sl_HSEL (HSEL), .sl_HREADY (out_sl_HREADY), .sl_HWRITE (HWRITE),
    .sl_HTRANS (HTRANS), .sl_HBURST (HBURST), .sl_HSIZE (HSIZE),
    .sl_HADDR (HADDR), .sl_HWDATA (HWDATA),
    .out_sl_HREADY (out_sl_HREADY), .out_sl_HRESP (out_sl_HRESP),
    .out_sl_HRDATA (out_sl_HRDATA),
    .out_valid (out_valid), .out_ready (out_ready), .out_pix (out_pix),
    .out_sof (out_sof), .out_eol (out_eol)
`ifdef FRAME_STREAMER_IRQ_EN
    , .irq (irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  // Beat recorder: a beat offered with ready high transfers on the next rising edge.
  always begin
    @(negedge HCLK);
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1 && nb < 64) begin
      b_pix[nb] = out_pix;
      b_sof[nb] = out_sof;
      b_eol[nb] = out_eol;
      nb++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = d;
    #1;
    n = 0;
    while (out_sl_HREADY !== 1'b1 && n < 100) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk("wr_hready", {63'd0, out_sl_HREADY}, 64'd1);
  endtask

  task automatic ahb_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    #1;
    d = out_sl_HRDATA;
  endtask

  task automatic wait_beats(input int want);
    int n;
    n = 0;
    while (nb < want && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    chk("beat_count", 64'(nb), 64'(want));
  endtask

  logic [31:0] rd;
  logic [31:0] fpx [8];
  logic [47:0] exp_pix [4];
  logic        exp_sof [4];
  logic        exp_eol [4];
  int          nb0;

  initial begin
    fpx = '{32'h010203, 32'h020202, 32'h030303, 32'h040404,
            32'h050505, 32'h060606, 32'h070707, 32'h080808};
    exp_pix = '{48'h020202_010203, 48'h040404_030303, 48'h060606_050505, 48'h080808_070707};
    exp_sof = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_eol = '{1'b0, 1'b1, 1'b0, 1'b1};

    HRESETn = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HTRANS = HTRANS_IDLE;
    HBURST = 3'd0; HSIZE = 3'd2; HADDR = '0; HWDATA = '0; out_ready = 1'b0;
    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_hready", {63'd0, out_sl_HREADY}, 64'd1);
    chk("rst_hresp",  {62'd0, out_sl_HRESP}, 64'd0);
    chk("rst_hrdata", {32'd0, out_sl_HRDATA}, 64'd0);
    chk("rst_valid",  {63'd0, out_valid}, 64'd0);
    chk("rst_pix",    {16'd0, out_pix}, 64'd0);
    chk("rst_sof",    {63'd0, out_sof}, 64'd0);
    chk("rst_eol",    {63'd0, out_eol}, 64'd0);
    HRESETn = 1'b1;
    ahb_rd(A_STATUS, rd); chk("rst_status", {32'd0, rd}, 64'h0000_0001);
    ahb_rd(A_SIZE, rd);   chk("rst_size",   {32'd0, rd}, 64'h0100_0100);
    ahb_rd(A_CTRL, rd);   chk("rst_ctrl",   {32'd0, rd}, 64'h0);

    // 4x2 frame of 8 pixels with a free-running sink.
    out_ready = 1'b1;
    ahb_wr(A_SIZE, 32'h0002_0004);
    ahb_wr(A_CTRL, 32'h1);
    ahb_wr(A_DATA, fpx[0]);
    ahb_wr(A_DATA, fpx[1]);
    @(negedge HCLK); #1; chk("lat_c1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge HCLK); #1; chk("lat_c2_valid", {63'd0, out_valid}, 64'd1);
    for (int k = 2; k < 8; k++) ahb_wr(A_DATA, fpx[k]);
    wait_beats(4);
    repeat (3) @(negedge HCLK);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("frame_pix%0d", i), {16'd0, b_pix[i]}, {16'd0, exp_pix[i]});
      chk($sformatf("frame_sof%0d", i), {63'd0, b_sof[i]}, {63'd0, exp_sof[i]});
      chk($sformatf("frame_eol%0d", i), {63'd0, b_eol[i]}, {63'd0, exp_eol[i]});
    end
    ahb_rd(A_STATUS, rd); chk("frame_done", {32'd0, rd}, 64'h0000_0005);
    ahb_wr(A_CTRL, 32'h5);
    ahb_rd(A_STATUS, rd); chk("done_cleared", {32'd0, rd}, 64'h0000_0001);

    // Fill all 16 entries plus one slot; the next pixel must stall the bus.
    out_ready = 1'b0;
    for (int i = 0; i < 33; i++) ahb_wr(A_DATA, 32'h0010_0000 + 32'(i));
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = A_DATA;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h0010_0021;
    #1; chk("stall_hready", {63'd0, out_sl_HREADY}, 64'd0);
    repeat (3) @(negedge HCLK);
    #1;
    chk("stall_hold",  {63'd0, out_sl_HREADY}, 64'd0);
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    chk("stall_pix",   {16'd0, out_pix}, {16'd0, 48'h100001_100000});
    @(negedge HCLK); out_ready = 1'b1;
    #1; chk("stall_release", {63'd0, out_sl_HREADY}, 64'd1);
    @(negedge HCLK); out_ready = 1'b0;
    #1; chk("post_release_hready", {63'd0, out_sl_HREADY}, 64'd1);
    ahb_rd(A_STATUS, rd); chk("level_full", {32'd0, rd}, 64'h0010_0002);

    // Clearing enable must not withdraw the beat already offered.
    ahb_wr(A_CTRL, 32'h0);
    repeat (2) @(negedge HCLK);
    #1;
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_pix",   {16'd0, out_pix}, {16'd0, 48'h100003_100002});
    @(negedge HCLK); out_ready = 1'b1;
    @(negedge HCLK); out_ready = 1'b0;
    #1; chk("drop_valid", {63'd0, out_valid}, 64'd0);
    ahb_rd(A_STATUS, rd); chk("level_15", {32'd0, rd}, 64'h000F_0000);

    // Counters sit at row 1, so SIZE is locked until a soft clear.
    ahb_wr(A_SIZE, 32'h0003_0006);
    ahb_rd(A_SIZE, rd); chk("size_locked", {32'd0, rd}, 64'h0002_0004);
    for (int i = 0; i < 3; i++) ahb_wr(A_DATA, 32'h0030_0000 + 32'(i));
    ahb_wr(A_CTRL, 32'h3);
    ahb_rd(A_STATUS, rd); chk("clr_status", {32'd0, rd}, 64'h0000_0001);
    ahb_rd(A_CTRL, rd);   chk("clr_ctrl",   {32'd0, rd}, 64'h0000_0001);
    ahb_wr(A_SIZE, 32'h0001_0002);
    ahb_rd(A_SIZE, rd);   chk("size_open",  {32'd0, rd}, 64'h0001_0002);
    out_ready = 1'b1;
    nb0 = nb;
    ahb_wr(A_DATA, 32'hFFAA_BBCC);
    ahb_wr(A_DATA, 32'h00DD_EEFF);
    wait_beats(nb0 + 1);
    chk("clr_pix", {16'd0, b_pix[nb0]}, {16'd0, 48'hDDEEFF_AABBCC});
    chk("clr_sof", {63'd0, b_sof[nb0]}, 64'd1);
    chk("clr_eol", {63'd0, b_eol[nb0]}, 64'd1);
    repeat (3) @(negedge HCLK);
    ahb_rd(A_STATUS, rd); chk("clr_frame_done", {32'd0, rd}, 64'h0000_0005);

`ifdef FRAME_STREAMER_IRQ_EN
    ahb_wr(A_CTRL, 32'hD);
    @(negedge HCLK); #1; chk("irq_low", {63'd0, irq}, 64'd0);
    nb0 = nb;
    ahb_wr(A_DATA, 32'h0011_2233);
    ahb_wr(A_DATA, 32'h0044_5566);
    wait_beats(nb0 + 1);
    repeat (3) @(negedge HCLK);
    #1; chk("irq_set", {63'd0, irq}, 64'd1);
    ahb_wr(A_CTRL, 32'hD);
    chk("irq_before_clr", {63'd0, irq}, 64'd1);
    @(negedge HCLK); #1; chk("irq_cleared", {63'd0, irq}, 64'd0);
`endif

    ahb_wr(A_CTRL, 32'h9);
    ahb_rd(A_CTRL, rd);
`ifdef FRAME_STREAMER_IRQ_EN
    chk("ctrl_bit3", {32'd0, rd}, 64'h9);
`else
    chk("ctrl_bit3", {32'd0, rd}, 64'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
